// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit-stream arbiter.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Gap counter must hold MAX_GAP itself; keep at least one bit when the watchdog is off.
  function automatic int gap_width(input int max_gap);
    return (max_gap > 0) ? $clog2(max_gap + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] sel_o,
  output logic               any_o
);

  int  idx;
  logic found;

  always_comb begin
    sel_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && valid_i[j]) begin
          sel_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    any_o = |valid_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmit byte stream between
// NUM_REQ requesters, with a stall watchdog that releases an abandoned lock.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_GAP = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = gap_width(MAX_GAP);
  localparam bit WD_ON = (MAX_GAP > 0);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                timeout_q, timeout_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  logic [NUM_REQ-1:0]  pick_sel;
  logic                pick_any;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    ptr_next;
  logic [BYTE_W-1:0]   cur_byte;
  logic                cur_valid;
  logic                cur_last;
  logic                slot_free;
  logic                accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .sel_o   (pick_sel),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_sel[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // Owner's byte stream, selected by the one-hot grant.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_byte = cur_byte | (req_data_i[i*BYTE_W +: BYTE_W] & {BYTE_W{grant_q[i]}});
    end
    cur_valid = |(req_valid_i & grant_q);
    cur_last  = |(req_last_i & grant_q);
  end

  assign ptr_next    = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
  assign slot_free   = ~tx_valid_q | tx_ready_i;
  assign req_ready_o = ((state_q == ARB_LOCKED) && slot_free) ? grant_q : '0;
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        gap_d = '0;
        if (pick_any) begin
          state_d = ARB_LOCKED;
          grant_d = pick_sel;
          gidx_d  = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (accept && cur_last) begin
          state_d = ARB_IDLE;
          ptr_d   = ptr_next;
          grant_d = '0;
          gap_d   = '0;
        end else if (cur_valid) begin
          gap_d = '0;
        end else if (WD_ON) begin
          // Owner has gone quiet mid-packet; release once the gap reaches MAX_GAP.
          if (gap_q == GAP_W'(MAX_GAP - 1)) begin
            timeout_d = 1'b1;
            state_d   = ARB_IDLE;
            ptr_d     = ptr_next;
            grant_d   = '0;
            gap_d     = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output register runs independently of the FSM so re-arbitration overlaps a pending byte.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (accept) begin
      tx_data_d  = cur_byte;
      tx_valid_d = 1'b1;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      gap_q      <= '0;
      timeout_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      gap_q      <= gap_d;
      timeout_q  <= timeout_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;
  assign busy_o     = (state_q == ARB_LOCKED) | tx_valid_q;

endmodule
